// File: rtl/ethernet_ipv4_tx_framer.sv
// Ethernet/IPv4 transmit framer: Eth header, IPv4 header with checksum, payload, zero pad, CRC-32 FCS.
// Latency: first header byte offered the cycle after metadata accept; payload bytes pass through combinationally.
// Backpressure: every output beat stalls on m_axis_tready; in S_PAY upstream sees m_axis_tready directly.
module ethernet_ipv4_tx_framer #(
   parameter int          DATA_WIDTH  = 8,
   parameter logic [7:0]  TTL         = 8'd64,
   parameter logic [15:0] MAX_PAYLOAD = 16'd1480,
   parameter bit          PAD_EN      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  meta_valid,
   output logic                  meta_ready,
   input  logic [47:0]           meta_dst_mac,
   input  logic [47:0]           meta_src_mac,
   input  logic [31:0]           meta_src_ip,
   input  logic [31:0]           meta_dst_ip,
   input  logic [7:0]            meta_protocol,
   input  logic [15:0]           meta_payload_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  err_len
);

   typedef enum logic [2:0] {S_IDLE, S_ETH, S_IP, S_PAY, S_PAD, S_FCS, S_DRAIN} state_t;

   state_t      state_q, state_d, after_pay;
   logic [15:0] cnt_q, cnt_d;
   logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
   logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
   logic [7:0]  proto_q, proto_d;
   logic [15:0] len_q, len_d, id_q, id_d, csum_q, csum_d;
   logic [31:0] crc_q, crc_d;
   logic        short_q, short_d, drain_q, drain_d, err_q, err_d;

   logic [15:0] total_len, csum_calc, fold2;
   logic [19:0] hsum;
   logic [16:0] fold1;
   logic [7:0]  eth_b [14];
   logic [7:0]  ip_b  [20];
   logic [7:0]  out_byte;
   logic        out_vld, out_last, beat, drain_fire, err_ev, pad_needed;

   // One byte of the reflected CRC-32 (poly EDB88320), LSB of the byte first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   // Header checksum: 20-bit sum of the ten header words, folded twice (second fold cannot carry).
   always_comb begin
      total_len = 16'd20 + len_q;
      hsum = 20'h04500 + {4'd0, total_len} + {4'd0, id_q} + 20'h04000 + {4'd0, TTL, proto_q}
           + {4'd0, src_ip_q[31:16]} + {4'd0, src_ip_q[15:0]}
           + {4'd0, dst_ip_q[31:16]} + {4'd0, dst_ip_q[15:0]};
      fold1 = {1'b0, hsum[15:0]} + {13'd0, hsum[19:16]};
      fold2 = fold1[15:0] + {15'd0, fold1[16]};
      csum_calc = ~fold2;
   end

   // Header byte tables, indexed by the per-state byte counter.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         eth_b[i]     = dst_mac_q[8*(5-i) +: 8];
         eth_b[i + 6] = src_mac_q[8*(5-i) +: 8];
      end
      eth_b[12] = 8'h08;
      eth_b[13] = 8'h00;
      ip_b[0]  = 8'h45;            ip_b[1]  = 8'h00;
      ip_b[2]  = total_len[15:8];  ip_b[3]  = total_len[7:0];
      ip_b[4]  = id_q[15:8];       ip_b[5]  = id_q[7:0];
      ip_b[6]  = 8'h40;            ip_b[7]  = 8'h00;
      ip_b[8]  = TTL;              ip_b[9]  = proto_q;
      ip_b[10] = csum_q[15:8];     ip_b[11] = csum_q[7:0];
      for (int i = 0; i < 4; i++) begin
         ip_b[12 + i] = src_ip_q[8*(3-i) +: 8];
         ip_b[16 + i] = dst_ip_q[8*(3-i) +: 8];
      end
   end

   // Output beat mux: constant-driven beats in header/pad/FCS, pass-through or zero fill in payload.
   always_comb begin
      out_vld  = 1'b0;
      out_byte = 8'h00;
      out_last = 1'b0;
      case (state_q)
         S_ETH: begin out_vld = 1'b1; out_byte = eth_b[cnt_q[3:0]]; end
         S_IP:  begin out_vld = 1'b1; out_byte = ip_b[cnt_q[4:0]]; end
         S_PAY: begin
            out_vld  = short_q ? 1'b1 : s_axis_tvalid;
            out_byte = short_q ? 8'h00 : s_axis_tdata;
         end
         S_PAD: out_vld = 1'b1;
         S_FCS: begin
            out_vld  = 1'b1;
            out_byte = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
            out_last = (cnt_q[1:0] == 2'd3);
         end
         default: ;
      endcase
   end

   assign m_axis_tvalid = out_vld;
   assign m_axis_tdata  = out_byte;
   assign m_axis_tlast  = out_last;
   assign meta_ready    = (state_q == S_IDLE);
   // Payload is taken only while live in S_PAY; upstream bytes beyond the frame are discarded while draining.
   assign s_axis_tready = (state_q == S_PAY) ? (m_axis_tready && !short_q)
                                             : (drain_q || state_q == S_DRAIN);
   assign beat          = out_vld && m_axis_tready;
   assign drain_fire    = s_axis_tvalid && s_axis_tready && s_axis_tlast
                          && (drain_q || state_q == S_DRAIN);
   assign pad_needed    = PAD_EN && (len_q < 16'd26);
   assign after_pay     = pad_needed ? S_PAD : S_FCS;
   assign err_len       = err_q | err_ev;

   // Next-state, counters, CRC and error events.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dst_mac_d = dst_mac_q;
      src_mac_d = src_mac_q;
      src_ip_d  = src_ip_q;
      dst_ip_d  = dst_ip_q;
      proto_d   = proto_q;
      len_d     = len_q;
      id_d      = id_q;
      csum_d    = csum_q;
      crc_d     = crc_q;
      short_d   = short_q;
      drain_d   = drain_q;
      err_d     = 1'b0;
      err_ev    = 1'b0;
      if (drain_fire) begin
         drain_d = 1'b0;
         err_ev  = drain_q;
      end
      case (state_q)
         S_IDLE: begin
            crc_d   = 32'hFFFF_FFFF;
            cnt_d   = 16'd0;
            short_d = 1'b0;
            if (meta_valid) begin
               dst_mac_d = meta_dst_mac;
               src_mac_d = meta_src_mac;
               src_ip_d  = meta_src_ip;
               dst_ip_d  = meta_dst_ip;
               proto_d   = meta_protocol;
               len_d     = meta_payload_len;
               if (meta_payload_len > MAX_PAYLOAD) begin
                  state_d = S_DRAIN;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_ETH;
               end
            end
         end
         S_ETH: begin
            csum_d = csum_calc;
            if (beat) begin
               crc_d = crc_byte(crc_q, out_byte);
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'd13) begin
                  cnt_d   = 16'd0;
                  state_d = S_IP;
               end
            end
         end
         S_IP: begin
            if (beat) begin
               crc_d = crc_byte(crc_q, out_byte);
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'd19) begin
                  cnt_d   = 16'd0;
                  state_d = (len_q == 16'd0) ? after_pay : S_PAY;
               end
            end
         end
         S_PAY: begin
            if (beat) begin
               crc_d = crc_byte(crc_q, out_byte);
               cnt_d = cnt_q + 16'd1;
               if (!short_q && s_axis_tlast && cnt_q != len_q - 16'd1) begin
                  short_d = 1'b1;
                  err_ev  = 1'b1;
               end
               if (cnt_q == len_q - 16'd1) begin
                  drain_d = !short_q && !s_axis_tlast;
                  cnt_d   = 16'd0;
                  state_d = after_pay;
               end
            end
         end
         S_PAD: begin
            if (beat) begin
               crc_d = crc_byte(crc_q, out_byte);
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'd25 - len_q) begin
                  cnt_d   = 16'd0;
                  state_d = S_FCS;
               end
            end
         end
         S_FCS: begin
            if (beat) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'd3) begin
                  cnt_d   = 16'd0;
                  id_d    = id_q + 16'd1;
                  state_d = (drain_q && !drain_fire) ? S_DRAIN : S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (drain_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; async reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         dst_mac_q <= 48'd0;
         src_mac_q <= 48'd0;
         src_ip_q  <= 32'd0;
         dst_ip_q  <= 32'd0;
         proto_q   <= 8'd0;
         len_q     <= 16'd0;
         id_q      <= 16'd0;
         csum_q    <= 16'd0;
         crc_q     <= 32'hFFFF_FFFF;
         short_q   <= 1'b0;
         drain_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dst_mac_q <= dst_mac_d;
         src_mac_q <= src_mac_d;
         src_ip_q  <= src_ip_d;
         dst_ip_q  <= dst_ip_d;
         proto_q   <= proto_d;
         len_q     <= len_d;
         id_q      <= id_d;
         csum_q    <= csum_d;
         crc_q     <= crc_d;
         short_q   <= short_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_ethernet_ipv4_tx_framer.sv
// Bench for ethernet_ipv4_tx_framer: directed frames, scoreboard queue of expected output bytes.
// Expected frames come from a byte-level software model; hand-computed header values are checked too.
// Output sampled 2ns after the falling edge; inputs driven on the falling edge.
`timescale 1ns/1ps
module tb_ethernet_ipv4_tx_framer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        meta_valid = 1'b0;
   logic        meta_ready;
   logic [47:0] meta_dst_mac = '0, meta_src_mac = '0;
   logic [31:0] meta_src_ip = '0, meta_dst_ip = '0;
   logic [7:0]  meta_protocol = '0;
   logic [15:0] meta_payload_len = '0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
   logic        err_len;

   always #5 clk = ~clk;

   ethernet_ipv4_tx_framer dut (
      .clk(clk), .rst_n(rst_n),
      .meta_valid(meta_valid), .meta_ready(meta_ready),
      .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
      .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip),
      .meta_protocol(meta_protocol), .meta_payload_len(meta_payload_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .err_len(err_len)
   );

   int          n_checks = 0, n_fail = 0;
   int          last_len = 0, err_cnt = 0;
   bit          rand_rdy = 1'b0;
   logic [15:0] id_model = 16'd0;
   logic [8:0]  exp_q[$];
   logic [7:0]  cap[$], last_frame[$], pay_drv[$], pay_emit[$];

   localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC = 48'h0200_0000_0001;
   localparam logic [31:0] SIP = 32'hC0A8_0001;
   localparam logic [31:0] DIP = 32'hC0A8_00C7;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // Software frame model; pushes {tlast, byte} for every expected beat.
   task automatic push_frame(input logic [7:0] proto, input logic [15:0] len);
      logic [7:0]  f[$];
      logic [15:0] tl, cs;
      logic [31:0] s, c;
      tl = 16'd20 + len;
      for (int i = 5; i >= 0; i--) f.push_back(DST[8*i +: 8]);
      for (int i = 5; i >= 0; i--) f.push_back(SRC[8*i +: 8]);
      f.push_back(8'h08); f.push_back(8'h00);
      s = 32'h4500 + {16'd0, tl} + {16'd0, id_model} + 32'h4000 + {16'd0, 8'd64, proto}
        + {16'd0, SIP[31:16]} + {16'd0, SIP[15:0]} + {16'd0, DIP[31:16]} + {16'd0, DIP[15:0]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      f.push_back(8'h45); f.push_back(8'h00); f.push_back(tl[15:8]); f.push_back(tl[7:0]);
      f.push_back(id_model[15:8]); f.push_back(id_model[7:0]); f.push_back(8'h40); f.push_back(8'h00);
      f.push_back(8'd64); f.push_back(proto); f.push_back(cs[15:8]); f.push_back(cs[7:0]);
      for (int i = 3; i >= 0; i--) f.push_back(SIP[8*i +: 8]);
      for (int i = 3; i >= 0; i--) f.push_back(DIP[8*i +: 8]);
      foreach (pay_emit[i]) f.push_back(pay_emit[i]);
      while (f.size() < 60) f.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      foreach (f[i]) c = crc_upd(c, f[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
      foreach (f[i]) exp_q.push_back({(i == f.size() - 1), f[i]});
      id_model = id_model + 16'd1;
   endtask

   task automatic set_pay(input int n, input logic [7:0] seed);
      pay_drv.delete();
      for (int i = 0; i < n; i++) pay_drv.push_back(seed + 8'(i * 7));
      pay_emit = pay_drv;
   endtask

   task automatic send_meta(input logic [7:0] proto, input logic [15:0] len);
      int n;
      n = 0;
      @(negedge clk);
      meta_dst_mac = DST; meta_src_mac = SRC; meta_src_ip = SIP; meta_dst_ip = DIP;
      meta_protocol = proto; meta_payload_len = len; meta_valid = 1'b1;
      #1;
      while (!meta_ready && n < 5000) begin @(negedge clk); #1; n++; end
      if (n >= 5000) begin n_checks++; n_fail++; $display("FAIL meta_timeout: meta_ready never 1"); end
      @(posedge clk);
      @(negedge clk);
      meta_valid = 1'b0;
   endtask

   task automatic send_pay(input int tlast_at, input bit gaps);
      int g;
      for (int i = 0; i < pay_drv.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
         end
         @(negedge clk);
         s_axis_tvalid = 1'b1; s_axis_tdata = pay_drv[i]; s_axis_tlast = (i == tlast_at);
         #1;
         g = 0;
         while (!s_axis_tready && g < 3000) begin @(negedge clk); #1; g++; end
         if (g >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL pay_timeout: byte %0d never accepted", i);
            break;
         end
         @(posedge clk);
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !meta_ready) && n < 5000) begin @(negedge clk); n++; end
      check({name, "_complete"}, 160'(n < 5000), 160'(1));
   endtask

   task automatic check_residue(input string name);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      foreach (last_frame[i]) r = crc_upd(r, last_frame[i]);
      check({name, "_fcs_residue"}, 160'(r), 160'(32'hDEBB_20E3));
   endtask

   // Downstream ready: always 1 or a 50% coin per cycle.
   initial forever begin
      @(negedge clk);
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Error pulse counter.
   initial forever begin
      @(negedge clk); #2;
      if (rst_n && err_len) err_cnt++;
   end

   // Monitor: scoreboard compare on every accepted beat, plus hold check while stalled.
   initial begin : monitor
      logic [7:0] held_d;
      logic       held_l, stalled;
      logic [8:0] e;
      stalled = 1'b0; held_d = '0; held_l = 1'b0;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin stalled = 1'b0; cap.delete(); continue; end
         if (stalled)
            check("stall_hold", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                  160'({1'b1, held_l, held_d}));
         stalled = m_axis_tvalid && !m_axis_tready;
         held_d = m_axis_tdata; held_l = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               check("beat", 160'({m_axis_tlast, m_axis_tdata}), 160'(e));
            end
            cap.push_back(m_axis_tdata);
            if (m_axis_tlast) begin
               last_frame = cap;
               last_len = cap.size();
               cap.delete();
            end
         end
      end
   end

   task automatic check_idle_outputs(input string name);
      check({name, "_outs"}, 160'({meta_ready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, err_len}),
            160'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
   endtask

   initial begin : stim
      logic [159:0] iph;
      int e0, n;
      #12;
      check_idle_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      // Frame 1: hand-computed IPv4 header, 95-byte payload.
      set_pay(95, 8'h00);
      push_frame(8'h11, 16'd95);
      send_meta(8'h11, 16'd95);
      send_pay(94, 1'b0);
      wait_done("f1");
      check("f1_beats", 160'(last_len), 160'(133));
      iph = '0;
      for (int i = 0; i < 20; i++) iph = {iph[151:0], last_frame[14 + i]};
      check("f1_ipv4_hdr", iph, 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7);
      check("f1_err", 160'(err_cnt), 160'(0));

      // Frame 2: len 4, padded to 64 beats.
      set_pay(4, 8'hDE);
      push_frame(8'h06, 16'd4);
      send_meta(8'h06, 16'd4);
      send_pay(3, 1'b0);
      wait_done("f2");
      check("f2_beats", 160'(last_len), 160'(64));
      check("f2_total_len", 160'({last_frame[16], last_frame[17]}), 160'(16'h0018));
      check_residue("f2");

      // Three back-to-back frames with random downstream stalls and upstream gaps.
      rand_rdy = 1'b1;
      set_pay(26, 8'h31); push_frame(8'h11, 16'd26); send_meta(8'h11, 16'd26); send_pay(25, 1'b1);
      set_pay(0, 8'h00);  push_frame(8'h11, 16'd0);  send_meta(8'h11, 16'd0);  send_pay(0, 1'b1);
      set_pay(30, 8'h77); push_frame(8'h11, 16'd30); send_meta(8'h11, 16'd30); send_pay(29, 1'b1);
      wait_done("rand");
      check("rand_beats", 160'(last_len), 160'(34 + 30 + 4));
      check_residue("rand");
      rand_rdy = 1'b0;

      // Early tlast on byte 6 of 10: remaining bytes zero-filled.
      e0 = err_cnt;
      set_pay(6, 8'hA0);
      for (int i = 0; i < 4; i++) pay_emit.push_back(8'h00);
      push_frame(8'h11, 16'd10);
      send_meta(8'h11, 16'd10);
      send_pay(5, 1'b0);
      wait_done("early");
      check("early_err", 160'(err_cnt - e0), 160'(1));
      check("early_beats", 160'(last_len), 160'(64));
      check_residue("early");

      // Missing tlast: 7 upstream bytes for len 4, extra bytes drained.
      e0 = err_cnt;
      set_pay(7, 8'h50);
      pay_emit = pay_drv[0:3];
      push_frame(8'h11, 16'd4);
      send_meta(8'h11, 16'd4);
      send_pay(6, 1'b0);
      wait_done("drain");
      check("drain_err", 160'(err_cnt - e0), 160'(1));
      check("drain_sready", 160'(s_axis_tready), 160'(0));

      // Oversize: nothing emitted, upstream drained through tlast.
      e0 = err_cnt;
      set_pay(5, 8'h10);
      send_meta(8'h11, 16'd2000);
      send_pay(4, 1'b0);
      wait_done("over");
      check("over_err", 160'(err_cnt - e0), 160'(1));
      check("over_meta_ready", 160'(meta_ready), 160'(1));

      // Reset while the IPv4 header is being sent.
      set_pay(4, 8'h01);
      push_frame(8'h11, 16'd4);
      send_meta(8'h11, 16'd4);
      n = 0;
      while (cap.size() < 17 && n < 1000) begin @(negedge clk); n++; end
      check("reach_ip", 160'(n < 1000), 160'(1));
      rst_n = 1'b0;
      exp_q.delete();
      id_model = 16'd0;
      #1;
      check_idle_outputs("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_frame(8'h11, 16'd4);
      send_meta(8'h11, 16'd4);
      send_pay(3, 1'b0);
      wait_done("post_reset");
      check("post_reset_beats", 160'(last_len), 160'(64));
      check("post_reset_id", 160'({last_frame[18], last_frame[19]}), 160'(16'h0000));

      check("queue_empty", 160'(exp_q.size()), 160'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      n_checks++; n_fail++;
      $display("FAIL watchdog: test did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
